// File: rtl/lsu_dmem.sv
// lsu_dmem: single-clock data memory for the LSU with a valid/ready request
// and response handshake, configurable read latency, and alignment, range
// and op-legality checking. Byte-addressable, little-endian.
module lsu_dmem #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LAT      = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [31:0]     req_addr,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic [1:0]      rsp_err
);

  localparam int unsigned NB        = XLEN / 8;
  localparam int unsigned LW        = $clog2(NB);
  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * NB);
  localparam logic [1:0]  CNT_INIT  = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [XLEN-1:0]   rsp_rdata_q;
  logic [1:0]        rsp_err_q;
  logic [1:0]        cnt_q;

  logic [XLEN-1:0]   mem_q [DEPTH_WORDS];

  logic [31:0]       off;
  logic [1:0]        size;
  logic              illegal;
  logic              misal;
  logic              oor;
  logic [1:0]        err_d;
  logic [AW-1:0]     idx;
  logic [LW-1:0]     lane;
  logic [NB-1:0]     lane_mask;
  logic [XLEN-1:0]   wdata_sh;
  logic [XLEN-1:0]   rword_sh;
  logic [XLEN-1:0]   rdata_d;
  logic              accept;
  logic              wr_en;

  // Extend the low w bits of v to XLEN, sign- or zero-filling above bit w-1.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input int unsigned     w,
                                             input logic            sgn);
    logic [XLEN-1:0] r;
    r = v;
    if (w < XLEN) begin
      for (int unsigned i = 0; i < XLEN; i++) begin
        if (i >= w) r[i] = sgn & v[w-1];
      end
    end
    return r;
  endfunction

  // Request decode: legality, alignment, range, lane selection and load data.
  always_comb begin
    off     = req_addr - BASE_ADDR;
    size    = req_op[1:0];
    illegal = (req_op == 3'b111) ||
              ((XLEN == 32) && ((req_op == 3'b011) || (req_op == 3'b110)));
    case (size)
      2'd1:    misal = req_addr[0];
      2'd2:    misal = (req_addr[1:0] != 2'b00);
      2'd3:    misal = (req_addr[2:0] != 3'b000);
      default: misal = 1'b0;
    endcase
    oor = (off >= MEM_BYTES);
    if (illegal)    err_d = 2'd3;
    else if (misal) err_d = 2'd1;
    else if (oor)   err_d = 2'd2;
    else            err_d = 2'd0;

    idx  = off[LW +: AW];
    lane = off[LW-1:0];

    lane_mask = '0;
    for (int unsigned l = 0; l < NB; l++) begin
      if ((l >= 32'(lane)) && (l < 32'(lane) + (32'd1 << size))) lane_mask[l] = 1'b1;
    end

    wdata_sh = req_wdata << {lane, 3'b000};
    rword_sh = mem_q[idx] >> {lane, 3'b000};

    if ((err_d != 2'd0) || req_wen) rdata_d = '0;
    else                            rdata_d = extend(rword_sh, 32'd8 << size, ~req_op[2]);
  end

  assign accept = (state_q == S_IDLE) && req_valid;
  assign wr_en  = accept && req_wen && (err_d == 2'd0) && !rst;

  // Store commit: only the lanes covered by the op are written; no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned l = 0; l < NB; l++) begin
        if (lane_mask[l]) mem_q[idx][8*l +: 8] <= wdata_sh[8*l +: 8];
      end
    end
  end

  // Handshake FSM with registered outputs; load data captured at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            rsp_rdata_q <= rdata_d;
            rsp_err_q   <= err_d;
            req_ready_q <= 1'b0;
            if (RD_LAT == 1) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Directed bench for lsu_dmem: three instances (32-bit lat 1, 32-bit lat 3,
// 64-bit lat 2) share the request bus; expected responses go through a queue.
module tb_lsu_dmem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_op = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  rsp_valid;
  logic        rsp_ready = 1'b0;

  logic [31:0] rd_a, rd_b;
  logic [63:0] rd_c;
  logic [1:0]  er_a, er_b, er_c;
  logic [63:0] rdata [3];
  logic [1:0]  rerr [3];

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  e;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rdata[0] = {32'd0, rd_a};
  assign rdata[1] = {32'd0, rd_b};
  assign rdata[2] = rd_c;
  assign rerr[0]  = er_a;
  assign rerr[1]  = er_b;
  assign rerr[2]  = er_c;

  lsu_dmem #(.XLEN(32), .DEPTH_WORDS(1024), .RD_LAT(1), .BASE_ADDR(32'h8000_0000)) u_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen), .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata[31:0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(er_a));

  lsu_dmem #(.XLEN(32), .DEPTH_WORDS(1024), .RD_LAT(3), .BASE_ADDR(32'h8000_0000)) u_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen), .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata[31:0]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(er_b));

  lsu_dmem #(.XLEN(64), .DEPTH_WORDS(1024), .RD_LAT(2), .BASE_ADDR(32'h8000_0000)) u_c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen), .req_addr(req_addr), .req_op(req_op), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd_c), .rsp_err(er_c));

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance i; hold = cycles of rsp_ready=0 backpressure.
  task automatic txn(input int i, input logic w, input logic [31:0] a, input logic [2:0] op,
                     input logic [63:0] wd, input logic [63:0] ed, input logic [1:0] ee,
                     input int hold, input string tag);
    exp_t e;
    int   n;
    chk({tag, "/ready_before"}, 64'(req_ready[i]), 64'd1);
    req_wen   = w;
    req_addr  = a;
    req_op    = op;
    req_wdata = wd;
    req_valid[i] = 1'b1;
    sb.push_back('{d: ed, e: ee});
    @(posedge clk); #1;
    req_valid = '0;
    n = 1;
    while (!rsp_valid[i] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "/latency"}, 64'(n), 64'(lat_of(i)));
    chk({tag, "/rsp_valid"}, 64'(rsp_valid[i]), 64'd1);
    if (sb.size() == 0) begin
      $display("FAIL %s/scoreboard: observed empty queue expected one entry", tag);
      $fatal(1, "scoreboard underflow");
    end
    e = sb.pop_front();
    chk({tag, "/rdata"}, rdata[i], e.d);
    chk({tag, "/err"}, 64'(rerr[i]), 64'(e.e));
    for (int k = 0; k < hold; k++) begin
      chk({tag, "/hold_req_ready"}, 64'(req_ready[i]), 64'd0);
      @(posedge clk); #1;
      chk({tag, "/hold_rsp_valid"}, 64'(rsp_valid[i]), 64'd1);
      chk({tag, "/hold_rdata"}, rdata[i], e.d);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "/valid_after"}, 64'(rsp_valid[i]), 64'd0);
    chk({tag, "/ready_after"}, 64'(req_ready[i]), 64'd1);
  endtask

  // Accept a request, then assert reset while it sits in WAIT; the response is dropped.
  task automatic txn_rst(input int i, input logic w, input logic [31:0] a, input logic [2:0] op,
                         input logic [63:0] wd, input string tag);
    req_wen   = w;
    req_addr  = a;
    req_op    = op;
    req_wdata = wd;
    req_valid[i] = 1'b1;
    @(posedge clk); #1;
    req_valid = '0;
    chk({tag, "/wait_rsp_valid"}, 64'(rsp_valid[i]), 64'd0);
    chk({tag, "/wait_req_ready"}, 64'(req_ready[i]), 64'd0);
    rst = 1'b1;
    #1;
    chk({tag, "/rst_rsp_valid"}, 64'(rsp_valid[i]), 64'd0);
    chk({tag, "/rst_req_ready"}, 64'(req_ready[i]), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  initial begin
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset/req_ready", 64'(req_ready[i]), 64'd1);
      chk("reset/rsp_valid", 64'(rsp_valid[i]), 64'd0);
      chk("reset/rdata", rdata[i], 64'd0);
      chk("reset/err", 64'(rerr[i]), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    // 32-bit, latency 1
    txn(0, 1, 32'h8000_0000, 3'b010, 64'hDEAD_BEEF, 64'd0, 2'd0, 0, "a_st_w");
    txn(0, 0, 32'h8000_0000, 3'b010, 64'd0, 64'hDEAD_BEEF, 2'd0, 0, "a_ld_w");
    txn(0, 1, 32'h8000_0003, 3'b000, 64'h80, 64'd0, 2'd0, 0, "a_st_b");
    txn(0, 0, 32'h8000_0003, 3'b000, 64'd0, 64'hFFFF_FF80, 2'd0, 0, "a_ld_b");
    txn(0, 0, 32'h8000_0003, 3'b100, 64'd0, 64'h0000_0080, 2'd0, 0, "a_ld_bu");
    txn(0, 1, 32'h8000_0002, 3'b001, 64'h1234, 64'd0, 2'd0, 0, "a_st_h");
    txn(0, 0, 32'h8000_0000, 3'b010, 64'd0, 64'h1234_BEEF, 2'd0, 0, "a_ld_w2");
    txn(0, 0, 32'h8000_0001, 3'b001, 64'd0, 64'd0, 2'd1, 0, "a_ld_h_mis");
    txn(0, 1, 32'h7FFF_FFFC, 3'b010, 64'h5555_5555, 64'd0, 2'd2, 0, "a_st_oor");
    txn(0, 1, 32'h8000_0002, 3'b010, 64'hFFFF_FFFF, 64'd0, 2'd1, 0, "a_st_mis");
    txn(0, 0, 32'h8000_0000, 3'b010, 64'd0, 64'h1234_BEEF, 2'd0, 0, "a_ld_unchanged");
    txn(0, 0, 32'h8000_0000, 3'b011, 64'd0, 64'd0, 2'd3, 0, "a_op_d_illegal");
    txn(0, 0, 32'h8000_0000, 3'b110, 64'd0, 64'd0, 2'd3, 0, "a_op_wu_illegal");
    txn(0, 0, 32'h8000_0001, 3'b111, 64'd0, 64'd0, 2'd3, 0, "a_op7_prio");
    txn(0, 0, 32'h7FFF_FFFD, 3'b010, 64'd0, 64'd0, 2'd1, 0, "a_mis_over_oor");
    txn(0, 1, 32'h8000_0FFC, 3'b010, 64'hCAFE_F00D, 64'd0, 2'd0, 0, "a_st_last");
    txn(0, 0, 32'h8000_0FFC, 3'b010, 64'd0, 64'hCAFE_F00D, 2'd0, 0, "a_ld_last");
    txn(0, 0, 32'h8000_1000, 3'b000, 64'd0, 64'd0, 2'd2, 0, "a_ld_past_end");

    // 32-bit, latency 3, backpressure and reset
    txn(1, 1, 32'h8000_0010, 3'b010, 64'hA5A5_5A5A, 64'd0, 2'd0, 0, "b_st_w");
    txn(1, 0, 32'h8000_0010, 3'b010, 64'd0, 64'hA5A5_5A5A, 2'd0, 5, "b_ld_hold");
    txn_rst(1, 1, 32'h8000_0020, 3'b010, 64'h1122_3344, "b_st_rst");
    txn_rst(1, 0, 32'h8000_0010, 3'b010, 64'd0, "b_ld_rst");
    txn(1, 0, 32'h8000_0020, 3'b010, 64'd0, 64'h1122_3344, 2'd0, 0, "b_ld_after_rst");
    txn(1, 0, 32'h8000_0012, 3'b101, 64'd0, 64'h0000_A5A5, 2'd0, 0, "b_ld_hu");

    // 64-bit, latency 2
    txn(2, 1, 32'h8000_0008, 3'b011, 64'h0123_4567_89AB_CDEF, 64'd0, 2'd0, 0, "c_st_d");
    txn(2, 0, 32'h8000_000C, 3'b110, 64'd0, 64'h0000_0000_0123_4567, 2'd0, 0, "c_ld_wu");
    txn(2, 0, 32'h8000_0008, 3'b010, 64'd0, 64'hFFFF_FFFF_89AB_CDEF, 2'd0, 0, "c_ld_w");
    txn(2, 0, 32'h8000_0008, 3'b011, 64'd0, 64'h0123_4567_89AB_CDEF, 2'd0, 0, "c_ld_d");
    txn(2, 0, 32'h8000_000F, 3'b000, 64'd0, 64'h0000_0000_0000_0001, 2'd0, 0, "c_ld_b");
    txn(2, 0, 32'h8000_000E, 3'b101, 64'd0, 64'h0000_0000_0000_0123, 2'd0, 0, "c_ld_hu");
    txn(2, 0, 32'h8000_0004, 3'b011, 64'd0, 64'd0, 2'd1, 0, "c_ld_d_mis");
    txn(2, 0, 32'h8000_2000, 3'b011, 64'd0, 64'd0, 2'd2, 0, "c_ld_oor");
    txn(2, 0, 32'h8000_0008, 3'b111, 64'd0, 64'd0, 2'd3, 0, "c_op7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Parametrised, single-clock data memory with a valid/ready request/response handshake and configurable read latency.
- Replaces the purely combinational DPI data port in the npc core: the LSU issues one load/store at a time and stalls until the response arrives.
- Memory is an internal byte-addressable, little-endian array with alignment, range and op-legality checking.

Parameters:
- XLEN, 32, data width; 32 or 64.
- DEPTH_WORDS, 1024, number of XLEN-bit words; power of two.
- RD_LAT, 1, cycles from request acceptance to rsp_valid; 1..4.
- BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_op  in  3  width/extension: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- req_wdata  in  XLEN  store data; low bytes used per op.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  XLEN  load result, extended per op.
- rsp_err  out  2  0 ok, 1 misaligned, 2 out of range, 3 illegal op.

Behaviour:
- Reset (async): state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter 0.
- Memory contents are not reset.
- FSM states:
  - IDLE: req_ready=1. On req_valid, perform the check, store commit and load capture at that edge. Go to RESP if RD_LAT=1; otherwise go to WAIT with counter=RD_LAT-2.
  - WAIT: req_ready=0. Decrement counter; go to RESP when counter is 0.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid&&rsp_ready; then return to IDLE.
- Timing: rsp_valid rises exactly RD_LAT cycles after the accepting edge. req_ready stays 0 from acceptance until the cycle after the response handshake. At most one request is outstanding; throughput is one per RD_LAT+1 cycles minimum.
- Legality: ops 011 and 110 are illegal when XLEN=32; 111 is always illegal.
- Alignment:
  - h/hu: addr[0]=0.
  - w/wu: addr[1:0]=0.
  - d: addr[2:0]=0.
  - b/bu: any address.
- Range: off = req_addr - BASE_ADDR (32-bit wrap). Valid iff off < DEPTH_WORDS*XLEN/8; addresses below BASE wrap large and are therefore out of range.
- Error priority: illegal op (3) > misaligned (1) > out of range (2).
- Any error: no memory write, rsp_rdata=0; response latency is unchanged.
- Word index = off >> log2(XLEN/8); byte lane = off[log2(XLEN/8)-1:0].
- Store: writes only the lanes covered by the op, taking them from the low bytes of req_wdata. Other bytes are unchanged. rsp_rdata=0.
- Load:
  - Selected lanes are shifted to bit 0.
  - b/h/w are sign-extended to XLEN; bu/hu/wu are zero-extended; d is returned as-is.
  - For XLEN=32, op 010 returns the full word.
- Loads are captured at the accepting edge, so a later store cannot alter a pending response (none can be accepted anyway).
- rsp_valid is asserted regardless of rsp_ready; the consumer may hold off indefinitely.
- Reset mid-operation: the pending response is discarded. A store accepted before reset remains committed.
- Inputs other than req_valid are don't-care while req_ready=0.

Test Plan:
- XLEN=32, RD_LAT=1:
  - Store w 0xDEADBEEF @0x80000000, then load w @0x80000000 -> rsp_rdata=0xDEADBEEF, err 0.
  - rsp_valid rises exactly 1 cycle after each accept.
- Byte/half extension:
  - Store b 0x80 @0x80000003, then load b -> 0xFFFFFF80, load bu -> 0x00000080.
  - Store h 0x1234 @0x80000002, then load w @0x80000000 -> 0x1234EF.. with the low half unchanged (0x1234BEEF after the first test).
- Errors:
  - Load h @0x80000001 -> err 1, rdata 0.
  - Store w @0x7FFFFFFC -> err 2, and memory is unchanged (checked by a subsequent load).
  - Op 011 at XLEN=32 -> err 3.
- Backpressure with RD_LAT=3:
  - Hold rsp_ready=0 for 5 cycles -> rsp_valid stays 1, data stable, req_ready=0 throughout.
  - Release -> req_ready=1 the next cycle.
- XLEN=64:
  - Store d 0x0123456789ABCDEF @0x80000008, then load wu @0x8000000C -> 0x0000000001234567.
  - Load w @0x80000008 -> 0xFFFFFFFF89ABCDEF.
- Reset: assert rst in the WAIT state of a load -> rsp_valid=0 and req_ready=1 immediately (async).
  - A store accepted just before the reset is still readable after reset.
